// File: rtl/cpu_defs_pkg.sv
// Shared definitions for the control sequencer: opcodes, state encoding, IR field positions.
// Latency: n/a (constants and pure decode helpers only).
// Backpressure: n/a.
package cpu_defs_pkg;

  typedef logic [4:0] op_t;
  typedef logic [3:0] state_t;

  // Opcodes understood by the sequencer; anything else behaves as NOP
  localparam op_t OP_ADD  = 5'b00011;
  localparam op_t OP_SUB  = 5'b00100;
  localparam op_t OP_SHR  = 5'b00101;
  localparam op_t OP_SHL  = 5'b00110;
  localparam op_t OP_ROR  = 5'b00111;
  localparam op_t OP_ROL  = 5'b01000;
  localparam op_t OP_AND  = 5'b01001;
  localparam op_t OP_OR   = 5'b01010;
  localparam op_t OP_MUL  = 5'b01111;
  localparam op_t OP_DIV  = 5'b10000;
  localparam op_t OP_NEG  = 5'b10001;
  localparam op_t OP_NOT  = 5'b10010;
  localparam op_t OP_NOP  = 5'b11010;
  localparam op_t OP_HALT = 5'b11011;

  // State encoding, also exported on the debug port
  localparam state_t ST_IDLE = 4'd0;
  localparam state_t ST_T0   = 4'd1;
  localparam state_t ST_T1   = 4'd2;
  localparam state_t ST_T2   = 4'd3;
  localparam state_t ST_T3   = 4'd4;
  localparam state_t ST_T4   = 4'd5;
  localparam state_t ST_T5   = 4'd6;
  localparam state_t ST_T6   = 4'd7;
  localparam state_t ST_HALT = 4'd8;

  // IR field bit positions
  localparam int unsigned OP_MSB = 31;
  localparam int unsigned OP_LSB = 27;
  localparam int unsigned RA_LSB = 23;
  localparam int unsigned RB_LSB = 19;
  localparam int unsigned RC_LSB = 15;

  // MUL/DIV need the extra HI/LO writeback step
  function automatic logic is_muldiv_op(op_t op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

  // Two-operand ALU ops: Y gets Rb, ALU combines Y with Rc
  function automatic logic is_alu_op(op_t op);
    return (op inside {OP_ADD, OP_SUB, OP_SHR, OP_SHL, OP_ROR, OP_ROL, OP_AND, OP_OR})
           || is_muldiv_op(op);
  endfunction

  // Single-operand ops: Rb goes straight through the ALU into Z
  function automatic logic is_unary_op(op_t op);
    return (op == OP_NEG) || (op == OP_NOT);
  endfunction

endpackage

// File: rtl/reg_select_decoder.sv
// Register-select decoder: binary select to one-hot strobe vector, gated by an enable.
// Latency: combinational.
// Backpressure: none; output follows inputs directly.
module reg_select_decoder #(
  parameter int N  = 16,
  parameter int SW = 4
) (
  input  logic          en_i,
  input  logic [SW-1:0] sel_i,
  output logic [N-1:0]  onehot_o
);

  // Selects beyond N-1 simply produce no strobe
  always_comb begin
    onehot_o = '0;
    for (int i = 0; i < N; i++) begin
      if (en_i && (int'(sel_i) == i)) onehot_o[i] = 1'b1;
    end
  end

endmodule

// File: rtl/control_sequencer.sv
// Moore control unit sequencing fetch (T0-T2) and execute (T3-T6) strobes for the datapath.
// Latency: ALU 6, MUL/DIV 7, NEG/NOT 5, NOP 4 cycles, plus one per memory wait cycle in T1.
// Backpressure: T1 holds read until mem_done; stop is only honoured at instruction boundaries.
module control_sequencer
  import cpu_defs_pkg::*;
#(
  parameter int NUM_REGS = 16,
  parameter int OPW      = 5,
  parameter int RSW      = 4
) (
  input  logic                clock,
  input  logic                clear,
  input  logic [31:0]         ir,
  input  logic                mem_done,
  input  logic                stop,
  output logic                PCout,
  output logic                MARin,
  output logic                incPC,
  output logic                Zin,
  output logic                PCin,
  output logic                read,
  output logic                MDRin,
  output logic                MDRout,
  output logic                IRin,
  output logic                Yin,
  output logic                ZLowOut,
  output logic                ZHighOut,
  output logic                HIin,
  output logic                LOin,
  output logic [NUM_REGS-1:0] reg_in,
  output logic [NUM_REGS-1:0] reg_out,
  output logic [OPW-1:0]      alu_op,
  output logic                run,
  output logic [3:0]          state
);

  state_t         state_q, state_d;
  state_t         eoi_state;
  op_t            op;
  logic [RSW-1:0] ra, rb, rc;
  logic           in_en, out_en, out_use_rc;
  logic [RSW-1:0] out_sel;
  logic           unused_ir_bits;

  assign op = ir[OP_MSB:OP_LSB];
  assign ra = ir[RA_LSB +: RSW];
  assign rb = ir[RB_LSB +: RSW];
  assign rc = ir[RC_LSB +: RSW];

  // Low IR bits carry immediates the sequencer never looks at
  assign unused_ir_bits = ^ir[RC_LSB-1:0];

  // Where every completed instruction goes next
  assign eoi_state = stop ? ST_IDLE : ST_T0;

  // State register; clear abandons any instruction in flight
  always_ff @(posedge clock) begin
    if (clear) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state decode from the current step and the opcode class
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (!stop) state_d = ST_T0;
      ST_T0:   state_d = ST_T1;
      ST_T1:   if (mem_done) state_d = ST_T2;
      ST_T2:   state_d = ST_T3;
      ST_T3: begin
        if (is_alu_op(op) || is_unary_op(op)) state_d = ST_T4;
        else if (op == OP_HALT)               state_d = ST_HALT;
        else                                  state_d = eoi_state;
      end
      ST_T4:   state_d = is_alu_op(op) ? ST_T5 : eoi_state;
      ST_T5:   state_d = is_muldiv_op(op) ? ST_T6 : eoi_state;
      ST_T6:   state_d = eoi_state;
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_IDLE;
    endcase
  end

  // Moore strobe decode; each strobe covers the whole cycle of its step
  always_comb begin
    {PCout, MARin, incPC, Zin, PCin, read, MDRin,
     MDRout, IRin, Yin, ZLowOut, ZHighOut, HIin, LOin} = 14'b0;
    alu_op     = OPW'(OP_NOP);
    in_en      = 1'b0;
    out_en     = 1'b0;
    out_use_rc = 1'b0;
    case (state_q)
      ST_T0: begin
        PCout = 1'b1; MARin = 1'b1; incPC = 1'b1; Zin = 1'b1;
      end
      ST_T1: begin
        // Re-loading PC from Z while waiting is harmless: Z is unchanged
        ZLowOut = 1'b1; PCin = 1'b1; read = 1'b1; MDRin = 1'b1;
      end
      ST_T2: begin
        MDRout = 1'b1; IRin = 1'b1;
      end
      ST_T3: begin
        if (is_alu_op(op)) begin
          out_en = 1'b1; Yin = 1'b1;
        end else if (is_unary_op(op)) begin
          out_en = 1'b1; alu_op = OPW'(op); Zin = 1'b1;
        end
      end
      ST_T4: begin
        if (is_alu_op(op)) begin
          out_en = 1'b1; out_use_rc = 1'b1; alu_op = OPW'(op); Zin = 1'b1;
        end else if (is_unary_op(op)) begin
          ZLowOut = 1'b1; in_en = 1'b1;
        end
      end
      ST_T5: begin
        if (is_muldiv_op(op)) begin
          ZLowOut = 1'b1; LOin = 1'b1;
        end else if (is_alu_op(op)) begin
          ZLowOut = 1'b1; in_en = 1'b1;
        end
      end
      ST_T6: begin
        if (is_muldiv_op(op)) begin
          ZHighOut = 1'b1; HIin = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign out_sel = out_use_rc ? rc : rb;

  reg_select_decoder #(.N(NUM_REGS), .SW(RSW)) u_reg_in_dec (
    .en_i     (in_en),
    .sel_i    (ra),
    .onehot_o (reg_in)
  );

  reg_select_decoder #(.N(NUM_REGS), .SW(RSW)) u_reg_out_dec (
    .en_i     (out_en),
    .sel_i    (out_sel),
    .onehot_o (reg_out)
  );

  assign run   = (state_q != ST_IDLE) && (state_q != ST_HALT);
  assign state = state_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: per-cycle scoreboard built from the instruction step rules.
// Latency: n/a.
// Backpressure: n/a.
module tb_control_sequencer;
  import cpu_defs_pkg::*;

  logic        clock = 1'b0;
  logic        clear, mem_done, stop;
  logic [31:0] ir;
  logic PCout, MARin, incPC, Zin, PCin, read, MDRin, MDRout, IRin, Yin, ZLowOut, ZHighOut, HIin, LOin;
  logic [15:0] reg_in, reg_out;
  logic [4:0]  alu_op;
  logic        run;
  logic [3:0]  state;
  logic [13:0] strb;

  int n_checks = 0;
  int n_fail   = 0;

  // Strobe masks in the order of the strb concatenation
  localparam logic [13:0] M_PCOUT = 14'h2000, M_MARIN = 14'h1000, M_INCPC = 14'h0800,
                          M_ZIN = 14'h0400, M_PCIN = 14'h0200, M_READ = 14'h0100,
                          M_MDRIN = 14'h0080, M_MDROUT = 14'h0040, M_IRIN = 14'h0020,
                          M_YIN = 14'h0010, M_ZLO = 14'h0008, M_ZHI = 14'h0004,
                          M_HIIN = 14'h0002, M_LOIN = 14'h0001;
  localparam logic [4:0] NOP5 = 5'b11010;

  typedef struct {
    logic [3:0]  st;
    logic [13:0] strb;
    logic [15:0] rin;
    logic [15:0] rout;
    logic [4:0]  alu;
    logic        md;
  } step_t;

  step_t exp_q[$];

  control_sequencer dut (
    .clock(clock), .clear(clear), .ir(ir), .mem_done(mem_done), .stop(stop),
    .PCout(PCout), .MARin(MARin), .incPC(incPC), .Zin(Zin), .PCin(PCin), .read(read),
    .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin), .Yin(Yin), .ZLowOut(ZLowOut),
    .ZHighOut(ZHighOut), .HIin(HIin), .LOin(LOin), .reg_in(reg_in), .reg_out(reg_out),
    .alu_op(alu_op), .run(run), .state(state)
  );

  assign strb = {PCout, MARin, incPC, Zin, PCin, read, MDRin, MDRout, IRin, Yin,
                 ZLowOut, ZHighOut, HIin, LOin};

  always #5 clock = ~clock;

  function automatic logic quiet();
    return (strb == 14'b0) && (reg_in == 16'b0) && (reg_out == 16'b0) && (alu_op == NOP5);
  endfunction

  function automatic step_t mk(logic [3:0] st, logic [13:0] s, logic [15:0] ri,
                               logic [15:0] ro, logic [4:0] al, logic md);
    step_t e;
    e.st = st; e.strb = s; e.rin = ri; e.rout = ro; e.alu = al; e.md = md;
    return e;
  endfunction

  // Expected cycle-by-cycle behaviour of one instruction, starting at T0
  task automatic build_model(input logic [31:0] irv, input int waits);
    logic [4:0]  op;
    logic [15:0] one16, bra, brb, brc;
    bit          is_md, is_alu, is_un;
    op    = irv[31:27];
    one16 = 16'h0001;
    bra   = one16 << irv[26:23];
    brb   = one16 << irv[22:19];
    brc   = one16 << irv[18:15];
    is_md  = op inside {5'b01111, 5'b10000};
    is_alu = is_md || (op inside {[5'b00011:5'b01010]});
    is_un  = op inside {5'b10001, 5'b10010};
    exp_q.delete();
    exp_q.push_back(mk(ST_T0, M_PCOUT | M_MARIN | M_INCPC | M_ZIN, 0, 0, NOP5, 1'($urandom_range(0, 1))));
    for (int w = 0; w <= waits; w++)
      exp_q.push_back(mk(ST_T1, M_ZLO | M_PCIN | M_READ | M_MDRIN, 0, 0, NOP5, w == waits));
    exp_q.push_back(mk(ST_T2, M_MDROUT | M_IRIN, 0, 0, NOP5, 1'($urandom_range(0, 1))));
    if (is_alu) begin
      exp_q.push_back(mk(ST_T3, M_YIN, 0, brb, NOP5, 1'($urandom_range(0, 1))));
      exp_q.push_back(mk(ST_T4, M_ZIN, 0, brc, op, 1'($urandom_range(0, 1))));
      if (is_md) begin
        exp_q.push_back(mk(ST_T5, M_ZLO | M_LOIN, 0, 0, NOP5, 1'($urandom_range(0, 1))));
        exp_q.push_back(mk(ST_T6, M_ZHI | M_HIIN, 0, 0, NOP5, 1'($urandom_range(0, 1))));
      end else begin
        exp_q.push_back(mk(ST_T5, M_ZLO, bra, 0, NOP5, 1'($urandom_range(0, 1))));
      end
    end else if (is_un) begin
      exp_q.push_back(mk(ST_T3, M_ZIN, 0, brb, op, 1'($urandom_range(0, 1))));
      exp_q.push_back(mk(ST_T4, M_ZLO, bra, 0, NOP5, 1'($urandom_range(0, 1))));
    end else begin
      exp_q.push_back(mk(ST_T3, 14'b0, 0, 0, NOP5, 1'($urandom_range(0, 1))));
    end
  endtask

  // Entered mid-low-phase of a T0 cycle; returns mid-low-phase of the following cycle
  task automatic run_instr(input logic [31:0] irv, input int waits, input bit stop_t4,
                           input bit abort_t4, input bit rand_stop,
                           output int cycles, output int reads);
    step_t      e;
    logic [3:0] nxt;
    build_model(irv, waits);
    ir = irv;
    #1;
    cycles = 0;
    reads  = 0;
    for (int k = 0; k < exp_q.size(); k++) begin
      e = exp_q[k];
      n_checks++;
      if ({state, strb, reg_in, reg_out, alu_op, run} !== {e.st, e.strb, e.rin, e.rout, e.alu, 1'b1}) begin
        n_fail++;
        $display("FAIL step%0d ir=%h: got st=%0d strb=%h rin=%h rout=%h alu=%b run=%b, want st=%0d strb=%h rin=%h rout=%h alu=%b run=1",
                 k, irv, state, strb, reg_in, reg_out, alu_op, run, e.st, e.strb, e.rin, e.rout, e.alu);
      end
      n_checks++;
      if (((reg_in != 0) && (reg_out != 0)) || !$onehot0(reg_in) || !$onehot0(reg_out)) begin
        n_fail++;
        $display("FAIL strobe_rules ir=%h: got rin=%h rout=%h, want at most one bit in one vector", irv, reg_in, reg_out);
      end
      if (run === 1'b1)  cycles++;
      if (read === 1'b1) reads++;
      mem_done = e.md;
      if (abort_t4 && e.st == ST_T4) begin
        clear = 1'b1;
        @(negedge clock); #1;
        return;
      end
      if (stop_t4) begin
        if (e.st == ST_T4) stop = 1'b1;
      end else if (k == exp_q.size() - 1) stop = 1'b0;
      else if (rand_stop) stop = 1'($urandom_range(0, 1));
      else stop = 1'b0;
      @(negedge clock); #1;
    end
    if (irv[31:27] == 5'b11011) nxt = ST_HALT;
    else if (stop_t4)           nxt = ST_IDLE;
    else                        nxt = ST_T0;
    n_checks++;
    if (state !== nxt || run !== (nxt == ST_T0)) begin
      n_fail++;
      $display("FAIL next_state ir=%h: got st=%0d run=%b, want st=%0d run=%b", irv, state, run, nxt, nxt == ST_T0);
    end
  endtask

  task automatic test_reset();
    clear = 1'b1; stop = 1'b0; mem_done = 1'b0; ir = 32'h0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clock); #1;
      n_checks++;
      if (state !== ST_IDLE || run !== 1'b0 || !quiet()) begin
        n_fail++;
        $display("FAIL reset: got st=%0d run=%b strb=%h rin=%h rout=%h alu=%b, want st=0 run=0 all zero alu=11010",
                 state, run, strb, reg_in, reg_out, alu_op);
      end
    end
    clear = 1'b0;
    @(negedge clock); #1;
    n_checks++;
    if (state !== ST_T0 || run !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release: got st=%0d run=%b, want st=%0d run=1", state, run, ST_T0);
    end
  endtask

  task automatic test_latency(input logic [31:0] irv, input int want, input string name);
    int c, r;
    run_instr(irv, 0, 0, 0, 0, c, r);
    n_checks++;
    if (c !== want) begin
      n_fail++;
      $display("FAIL latency_%s: got %0d cycles, want %0d", name, c, want);
    end
  endtask

  task automatic test_fetch_wait();
    int c, r;
    run_instr(32'h1A1B8000, 3, 0, 0, 0, c, r);
    n_checks++;
    if (r !== 4 || c !== 9) begin
      n_fail++;
      $display("FAIL fetch_wait: got read_cycles=%0d total=%0d, want 4 and 9", r, c);
    end
  endtask

  task automatic test_random();
    int          c, r;
    logic [4:0]  op;
    logic [31:0] irv;
    for (int n = 0; n < 40; n++) begin
      do op = 5'($urandom_range(0, 31)); while (op == 5'b11011);
      irv = {op, 27'($urandom)};
      run_instr(irv, $urandom_range(0, 3), 0, 0, 1, c, r);
    end
  endtask

  task automatic test_stop();
    int c, r;
    run_instr(32'h1A1B8000, 1, 1, 0, 0, c, r);
    for (int i = 0; i < 3; i++) begin
      mem_done = 1'($urandom_range(0, 1));
      @(negedge clock); #1;
      n_checks++;
      if (state !== ST_IDLE || run !== 1'b0 || !quiet()) begin
        n_fail++;
        $display("FAIL stop_idle: got st=%0d run=%b strb=%h rin=%h, want IDLE and quiet", state, run, strb, reg_in);
      end
    end
    stop = 1'b0;
    @(negedge clock); #1;
    n_checks++;
    if (state !== ST_T0) begin
      n_fail++;
      $display("FAIL stop_release: got st=%0d, want %0d", state, ST_T0);
    end
  endtask

  task automatic test_halt();
    int c, r;
    run_instr(32'hD8000000, 1, 0, 0, 1, c, r);
    for (int i = 0; i < 10; i++) begin
      stop = 1'($urandom_range(0, 1));
      mem_done = 1'($urandom_range(0, 1));
      @(negedge clock); #1;
      n_checks++;
      if (state !== ST_HALT || run !== 1'b0 || !quiet()) begin
        n_fail++;
        $display("FAIL halt_hold: got st=%0d run=%b strb=%h, want st=%0d run=0 quiet", state, run, strb, ST_HALT);
      end
    end
    clear = 1'b1;
    @(negedge clock); #1;
    n_checks++;
    if (state !== ST_IDLE || run !== 1'b0) begin
      n_fail++;
      $display("FAIL halt_clear: got st=%0d run=%b, want st=0 run=0", state, run);
    end
    clear = 1'b0; stop = 1'b0;
    @(negedge clock); #1;
    n_checks++;
    if (state !== ST_T0) begin
      n_fail++;
      $display("FAIL halt_restart: got st=%0d, want %0d", state, ST_T0);
    end
  endtask

  task automatic test_clear_mid();
    int c, r;
    run_instr(32'h1A1B8000, 0, 0, 1, 0, c, r);
    n_checks++;
    if (state !== ST_IDLE || reg_in !== 16'b0 || !quiet()) begin
      n_fail++;
      $display("FAIL clear_mid: got st=%0d rin=%h strb=%h, want IDLE with no strobes", state, reg_in, strb);
    end
    clear = 1'b0; stop = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clock); #1;
      n_checks++;
      if (state !== ST_IDLE || reg_in !== 16'b0 || ZLowOut !== 1'b0) begin
        n_fail++;
        $display("FAIL clear_no_writeback: got st=%0d rin=%h zlo=%b, want IDLE rin=0 zlo=0", state, reg_in, ZLowOut);
      end
    end
    stop = 1'b0;
    @(negedge clock); #1;
    n_checks++;
    if (state !== ST_T0) begin
      n_fail++;
      $display("FAIL clear_restart: got st=%0d, want %0d", state, ST_T0);
    end
  endtask

  initial begin
    test_reset();
    test_latency(32'h1A1B8000, 6, "add");
    test_latency(32'h92800000, 5, "not");
    test_latency(32'h78090000, 7, "mul");
    test_latency(32'h8A000000, 5, "neg");
    test_latency(32'h80800000, 7, "div");
    test_latency(32'hD0000000, 4, "nop");
    test_fetch_wait();
    test_random();
    test_stop();
    test_halt();
    test_clear_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Moore-style control unit that drives the datapath's control strobes through instruction fetch (T0–T2) and execute (T3–T6).
- Supported classes: three-register ALU ops, MUL/DIV with HI/LO writeback, and unary NEG/NOT.
- Fetch uses a wait-state handshake with memory (`read` held until `mem_done`).
- Replaces the hand-sequenced strobes currently driven by benches; its outputs connect one-to-one to datapath control inputs.

Parameters:
- NUM_REGS, 16, number of general registers (width of `reg_in`/`reg_out`).
- OPW, 5, opcode width.
- RSW, 4, register-select field width in IR.

Ports:
- clock  in  1  system clock, rising edge.
- clear  in  1  synchronous active-high reset.
- ir  in  32  current IR contents. Fields: op=ir[31:27], Ra=ir[26:23], Rb=ir[22:19], Rc=ir[18:15].
- mem_done  in  1  memory data valid on Mdatain this cycle.
- stop  in  1  pause request, honoured only at instruction boundary.
- PCout, MARin, incPC, Zin, PCin, read, MDRin, MDRout, IRin, Yin, ZLowOut, ZHighOut, HIin, LOin  out  1 each  datapath strobes.
- reg_in  out  NUM_REGS  one-hot; bit i drives Ri_in.
- reg_out  out  NUM_REGS  one-hot; bit i drives Ri_out.
- alu_op  out  OPW  ALU opcode.
- run  out  1  high while sequencing instructions.
- state  out  4  current state encoding, for debug.

Behaviour:
- **Clock and reset.** One clock; reset is synchronous and active-high on `clear`.
- **Reset values.** When `clear`=1 at a rising edge:
  - state becomes IDLE.
  - All strobes, `reg_in` and `reg_out` are 0.
  - alu_op = NOP (5'b11010); run = 0.
  - A clear mid-instruction abandons it immediately; no partial writeback strobes are issued on later cycles.
- **Output timing.** All outputs are decoded combinationally from the registered state and latched `ir`. Each strobe is asserted for the whole cycle of its state. Outside T4 (ALU ops) and T3 (unary), alu_op = NOP.
- **States:** IDLE, T0, T1, T2, T3, T4, T5, T6, HALT.
- **Transitions and strobes:**
  - IDLE: run=0. Goes to T0 when stop=0.
  - T0: PCout, MARin, incPC, Zin. Goes to T1.
  - T1: ZLowOut, PCin, read, MDRin. Stays in T1 while mem_done=0 (re-loading PC from unchanged Z is benign). Goes to T2 on the cycle mem_done=1.
  - T2: MDRout, IRin. Goes to T3.
  - T3: decode of op.
    - ALU ops (ADD 00011, SUB 00100, SHR 00101, SHL 00110, ROR 00111, ROL 01000, AND 01001, OR 01010, MUL 01111, DIV 10000): reg_out[Rb], Yin. Goes to T4.
    - NEG 10001 / NOT 10010: reg_out[Rb], alu_op=op, Zin. Goes to T4.
    - HALT 11011: no strobes. Goes to HALT.
    - NOP 11010 or any undefined op: no strobes. Goes to the end-of-instruction step.
  - T4:
    - ALU ops: reg_out[Rc], alu_op=op, Zin. Goes to T5.
    - Unary ops: ZLowOut, reg_in[Ra]. Goes to the end-of-instruction step.
  - T5:
    - MUL/DIV: ZLowOut, LOin. Goes to T6.
    - Other ALU ops: ZLowOut, reg_in[Ra]. Goes to the end-of-instruction step.
  - T6 (MUL/DIV only): ZHighOut, HIin. Goes to the end-of-instruction step.
  - End of instruction: go to IDLE if stop=1, else T0.
  - HALT: run=0, all strobes 0. Left only via clear.
- **Strobe rules.** `reg_in` and `reg_out` are never both nonzero in the same cycle. At most one bit of each is set. Ra==Rb or Rb==Rc is legal and needs no special handling.
- **run.** run=1 in T0–T6; 0 in IDLE and HALT.
- **Latencies with mem_done=1 in the first T1 cycle:**
  - ALU ops: 6 cycles.
  - MUL/DIV: 7 cycles.
  - NEG/NOT: 5 cycles.
  - NOP: 4 cycles.
  - Each extra mem_done=0 cycle adds 1.
- **stop timing.** A stop asserted mid-instruction has no effect until the end-of-instruction step.

Decomposition:
- Shared package `cpu_defs_pkg`:
  - opcode localparams (ADD..HALT, NOP=5'b11010);
  - state encoding enum;
  - IR field bit positions.
- One sub-module: `reg_select_decoder` (4-to-16 one-hot decode with enable), instantiated twice: once for `reg_in`, once for `reg_out`.

Test Plan:
1. **Reset.** clear=1 for 2 cycles, then 0 with stop=0 → run=0 during reset, state=T0 one cycle after release, all strobes 0 during clear.
2. **ADD R4,R3,R7** (ir=0x1A1B8000, mem_done=1 in T1):
   - T3: reg_out=0x0008 and Yin.
   - T4: reg_out=0x0080, alu_op=00011, Zin.
   - T5: ZLowOut and reg_in=0x0010.
   - Next state T0 after 6 cycles.
3. **NOT R5,R0** (ir=0x92800000):
   - T3: reg_out=0x0001, alu_op=10010, Zin.
   - T4: ZLowOut and reg_in=0x0020.
   - Total 5 cycles.
4. **MUL R1,R2** (ir=0x78090000):
   - T5: ZLowOut and LOin.
   - T6: ZHighOut and HIin.
   - reg_in stays 0 throughout.
5. **Fetch wait.** mem_done held 0 for 3 cycles in T1 → read and MDRin high for 4 cycles; T2 entered the cycle after mem_done=1.
6. **Stop, clear and HALT:**
   - stop=1 raised in T4 of an ADD → writeback still occurs, then IDLE; releasing stop → T0.
   - ir=0xD8000000 (HALT) → HALT state with run=0, held 10 cycles; clear returns to IDLE.
   - clear asserted during T4 → IDLE next cycle, with no reg_in pulse.
